// File: rtl/wave_gen_pkg.sv
`timescale 1ns/1ps
// Shared types and reset constants for the DDS waveform generator.
package wave_gen_pkg;

    localparam int FREQ_W = 32;

    typedef enum logic [1:0] {
        SQUARE = 2'd0,
        SAW    = 2'd1,
        TRI    = 2'd2,
        SINE   = 2'd3
    } wave_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    typedef struct packed {
        logic [FREQ_W-1:0] freq;
        logic [7:0]        duty;
        logic [7:0]        max;
        logic [7:0]        min;
        wave_t             wave;
    } cfg_t;

    localparam logic [FREQ_W-1:0] RST_FREQ = '0;
    localparam logic [7:0]        RST_DUTY = 8'd128;
    localparam logic [7:0]        RST_MAX  = 8'd255;
    localparam logic [7:0]        RST_MIN  = 8'd0;
    localparam wave_t             RST_WAVE = SQUARE;

    localparam cfg_t RST_CFG = '{freq: RST_FREQ, duty: RST_DUTY, max: RST_MAX,
                                 min: RST_MIN, wave: RST_WAVE};

endpackage

// File: rtl/wave_gen_sine_lut.sv
`timescale 1ns/1ps
// Quarter-wave sine ROM: round(127*sin((2i+1)*pi/256)), registered output so it
// lines up with the raw-shape register in the top level.
module wave_gen_sine_lut (
    input  logic       clk,
    input  logic [5:0] i_addr,
    output logic [7:0] o_data
);

    localparam logic [7:0] SINE_Q [0:63] = '{
        8'd2,   8'd5,   8'd8,   8'd11,  8'd14,  8'd17,  8'd20,  8'd23,
        8'd26,  8'd29,  8'd32,  8'd35,  8'd38,  8'd41,  8'd44,  8'd47,
        8'd50,  8'd53,  8'd56,  8'd58,  8'd61,  8'd64,  8'd67,  8'd69,
        8'd72,  8'd74,  8'd77,  8'd79,  8'd82,  8'd84,  8'd86,  8'd89,
        8'd91,  8'd93,  8'd95,  8'd97,  8'd99,  8'd101, 8'd103, 8'd105,
        8'd106, 8'd108, 8'd110, 8'd111, 8'd113, 8'd114, 8'd115, 8'd117,
        8'd118, 8'd119, 8'd120, 8'd121, 8'd122, 8'd123, 8'd124, 8'd124,
        8'd125, 8'd125, 8'd126, 8'd126, 8'd127, 8'd127, 8'd127, 8'd127
    };

    logic [7:0] r_data;

    always_ff @(posedge clk) begin
        r_data <= SINE_Q[i_addr];
    end

    assign o_data = r_data;

endmodule

// File: rtl/wave_gen.sv
`timescale 1ns/1ps
// DDS waveform generator for the 8-bit DAC: phase accumulator -> raw shape ->
// min/max scaling, one register each; new settings swap in at a phase wrap.
module wave_gen
    import wave_gen_pkg::*;
#(
    parameter int CLK_FS  = 50_000_000,
    parameter int PHASE_W = 32
) (
    input  logic               clk_50M,
    input  logic               rst,
    input  logic               en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_freq_word,
    input  logic [7:0]         cfg_duty,
    input  logic [7:0]         cfg_max,
    input  logic [7:0]         cfg_min,
    input  logic [1:0]         cfg_wave,
    output logic [7:0]         da_data,
    output logic               sync_pulse
);

    if (CLK_FS <= 0 || PHASE_W != FREQ_W) begin : g_bad_params
        $error("wave_gen: CLK_FS must be positive and PHASE_W must equal FREQ_W");
    end

    state_t             r_state, w_stateNext;
    cfg_t               r_active, r_shadow, w_cfgIn;
    logic [PHASE_W-1:0] r_phaseAcc;
    logic [PHASE_W:0]   w_sum;
    logic               r_wrap, r_wrapD, r_sync;
    logic               w_xfer, w_takeInput, w_takeShadow, w_latchShadow;
    logic [7:0]         w_phase, w_rawNext, r_raw, w_raw, w_lutData, w_span, r_maxD, r_minD, r_da;
    logic [5:0]         w_lutAddr;
    logic               r_useLut, r_sineNeg;
    logic [15:0]        w_prod;

    assign cfg_ready = (r_state != PEND);
    assign w_xfer    = cfg_valid & cfg_ready;
    assign w_sum     = {1'b0, r_phaseAcc} + {1'b0, r_active.freq};
    assign w_phase   = r_phaseAcc[PHASE_W-1 -: 8];

    always_comb begin
        w_cfgIn.freq = cfg_freq_word;
        w_cfgIn.duty = cfg_duty;
        w_cfgIn.max  = cfg_max;
        w_cfgIn.min  = cfg_min;
        w_cfgIn.wave = wave_t'(cfg_wave);
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_stateNext;
    end

    // A config accepted while running waits in the shadow until the next carry;
    // with a zero increment no carry can come, so it applies straight away.
    always_comb begin
        w_stateNext   = r_state;
        w_takeInput   = 1'b0;
        w_takeShadow  = 1'b0;
        w_latchShadow = 1'b0;
        case (r_state)
            IDLE: begin
                w_takeInput = w_xfer;
                if (en) w_stateNext = RUN;
            end
            RUN: begin
                if (!en) begin
                    w_stateNext = IDLE;
                    w_takeInput = w_xfer;
                end else if (w_xfer) begin
                    w_latchShadow = 1'b1;
                    w_stateNext   = PEND;
                end
            end
            PEND: begin
                if (!en) begin
                    w_stateNext  = IDLE;
                    w_takeShadow = 1'b1;
                end else if (r_active.freq == '0 || w_sum[PHASE_W]) begin
                    w_stateNext  = RUN;
                    w_takeShadow = 1'b1;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_active   <= RST_CFG;
            r_shadow   <= '0;
            r_phaseAcc <= '0;
            r_wrap     <= 1'b0;
        end else begin
            if (w_takeInput)       r_active <= w_cfgIn;
            else if (w_takeShadow) r_active <= r_shadow;
            if (w_latchShadow)     r_shadow <= w_cfgIn;
            if (r_state == IDLE || w_stateNext == IDLE) begin
                r_phaseAcc <= '0;
                r_wrap     <= 1'b0;
            end else begin
                r_phaseAcc <= w_sum[PHASE_W-1:0];
                r_wrap     <= w_sum[PHASE_W];
            end
        end
    end

    always_comb begin
        w_rawNext = '0;
        case (r_active.wave)
            SQUARE:  w_rawNext = (w_phase < r_active.duty) ? 8'hFF : 8'h00;
            SAW:     w_rawNext = w_phase;
            TRI:     w_rawNext = w_phase[7] ? ~{w_phase[6:0], 1'b0} : {w_phase[6:0], 1'b0};
            default: w_rawNext = '0;
        endcase
        if (r_state == IDLE) w_rawNext = '0;
    end

    // Second and fourth quadrants read the table backwards.
    assign w_lutAddr = w_phase[6] ? ~w_phase[5:0] : w_phase[5:0];

    wave_gen_sine_lut u_sineLut (
        .clk    (clk_50M),
        .i_addr (w_lutAddr),
        .o_data (w_lutData)
    );

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_raw     <= '0;
            r_useLut  <= 1'b0;
            r_sineNeg <= 1'b0;
            r_maxD    <= RST_MAX;
            r_minD    <= RST_MIN;
            r_wrapD   <= 1'b0;
        end else begin
            r_raw     <= w_rawNext;
            r_useLut  <= (r_state != IDLE) && (r_active.wave == SINE);
            r_sineNeg <= w_phase[7];
            r_maxD    <= r_active.max;
            r_minD    <= r_active.min;
            r_wrapD   <= r_wrap;
        end
    end

    assign w_raw  = r_useLut ? (r_sineNeg ? 8'd127 - w_lutData : 8'd128 + w_lutData) : r_raw;
    assign w_span = (r_maxD > r_minD) ? r_maxD - r_minD : 8'd0;
    assign w_prod = {8'd0, w_span} * {8'd0, w_raw};

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_da   <= '0;
            r_sync <= 1'b0;
        end else begin
            r_da   <= r_minD + 8'(w_prod >> 8);
            r_sync <= r_wrapD;
        end
    end

    assign da_data    = r_da;
    assign sync_pulse = r_sync;

endmodule

// File: tb/tb_wave_gen.sv
`timescale 1ns/1ps
// Self-checking bench for wave_gen: table of fixed-phase samples plus
// hand-written sequences for period, pending-config, reset and enable cases.
module tb_wave_gen;
    import wave_gen_pkg::*;

    logic        clk_50M = 1'b0;
    logic        rst, en, cfg_valid, cfg_ready, sync_pulse;
    logic [31:0] cfg_freq_word;
    logic [7:0]  cfg_duty, cfg_max, cfg_min, da_data;
    logic [1:0]  cfg_wave;

    int checks = 0;
    int errors = 0;

    wave_gen #(.CLK_FS(50_000_000), .PHASE_W(32)) dut (
        .clk_50M       (clk_50M),
        .rst           (rst),
        .en            (en),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_freq_word (cfg_freq_word),
        .cfg_duty      (cfg_duty),
        .cfg_max       (cfg_max),
        .cfg_min       (cfg_min),
        .cfg_wave      (cfg_wave),
        .da_data       (da_data),
        .sync_pulse    (sync_pulse)
    );

    always #10 clk_50M = ~clk_50M;

    typedef struct {
        logic [1:0]  wave;
        logic [7:0]  duty;
        logic [7:0]  mx;
        logic [7:0]  mn;
        logic [31:0] freq;
        int          steps;
        logic [7:0]  expDa;
    } vec_t;

    vec_t vecs[15];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50M);
        #1;
    endtask

    task automatic setCfg(input logic [31:0] freq, input logic [7:0] duty, input logic [7:0] mx,
                          input logic [7:0] mn, input logic [1:0] wave);
        cfg_freq_word = freq;
        cfg_duty      = duty;
        cfg_max       = mx;
        cfg_min       = mn;
        cfg_wave      = wave;
    endtask

    task automatic applyStimulus(input logic [31:0] freq, input logic [7:0] duty, input logic [7:0] mx,
                                 input logic [7:0] mn, input logic [1:0] wave);
        setCfg(freq, duty, mx, mn, wave);
        cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
    endtask

    task automatic waitSync(input int limit, output int found, output int lows);
        found = 0;
        lows  = 0;
        for (int i = 0; i < limit; i++) begin
            tick(1);
            if (da_data == 8'd0) lows++;
            if (sync_pulse) begin
                found = 1;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int found, lows, highs, syncs;
        logic [7:0] lo, hi;

        vecs = '{
            '{SQUARE, 8'd128, 8'd255, 8'd0,   32'h0400_0000, 0,   8'd254},
            '{SQUARE, 8'd128, 8'd255, 8'd0,   32'h0400_0000, 31,  8'd254},
            '{SQUARE, 8'd128, 8'd255, 8'd0,   32'h0400_0000, 32,  8'd0},
            '{SQUARE, 8'd0,   8'd200, 8'd40,  32'h0400_0000, 0,   8'd40},
            '{SQUARE, 8'd255, 8'd200, 8'd40,  32'h0400_0000, 63,  8'd199},
            '{SAW,    8'd0,   8'd200, 8'd40,  32'h0100_0000, 0,   8'd40},
            '{SAW,    8'd0,   8'd200, 8'd40,  32'h0100_0000, 255, 8'd199},
            '{SAW,    8'd0,   8'd200, 8'd40,  32'h0100_0000, 128, 8'd120},
            '{TRI,    8'd0,   8'd255, 8'd0,   32'h0100_0000, 64,  8'd127},
            '{TRI,    8'd0,   8'd255, 8'd0,   32'h0100_0000, 192, 8'd126},
            '{TRI,    8'd0,   8'd255, 8'd0,   32'h0100_0000, 127, 8'd253},
            '{TRI,    8'd0,   8'd10,  8'd50,  32'h0100_0000, 100, 8'd50},
            '{SINE,   8'd0,   8'd100, 8'd100, 32'h0100_0000, 40,  8'd100},
            '{SAW,    8'd0,   8'd255, 8'd0,   32'h0080_0000, 5,   8'd1},
            '{SAW,    8'd0,   8'd255, 8'd0,   32'hFFFF_FFFF, 2,   8'd254}
        };

        rst = 1'b1;
        en = 1'b0;
        cfg_valid = 1'b0;
        setCfg(32'h0, 8'd0, 8'd0, 8'd0, 2'd0);
        tick(2);
        checkOutput("resetDa", da_data, 8'd0);
        checkOutput("resetSync", sync_pulse, 1'b0);
        checkOutput("resetReady", cfg_ready, 1'b1);
        rst = 1'b0;
        tick(1);

        foreach (vecs[v]) begin
            en = 1'b0;
            tick(1);
            applyStimulus(vecs[v].freq, vecs[v].duty, vecs[v].mx, vecs[v].mn, vecs[v].wave);
            tick(2);
            checkOutput($sformatf("vec%0dIdleMin", v), da_data, vecs[v].mn);
            en = 1'b1;
            tick(vecs[v].steps + 3);
            checkOutput($sformatf("vec%0dDa", v), da_data, vecs[v].expDa);
        end

        en = 1'b0;
        tick(1);
        applyStimulus(32'h0100_0000, 8'd0, 8'd200, 8'd40, SINE);
        en = 1'b1;
        tick(3);
        lo = 8'hFF;
        hi = 8'h00;
        for (int i = 0; i < 256; i++) begin
            if (da_data < lo) lo = da_data;
            if (da_data > hi) hi = da_data;
            tick(1);
        end
        checkOutput("sineLow", lo, 8'd40);
        checkOutput("sineHigh", hi, 8'd199);

        en = 1'b0;
        tick(1);
        applyStimulus(32'h0400_0000, 8'd128, 8'd255, 8'd0, SQUARE);
        en = 1'b1;
        waitSync(200, found, lows);
        checkOutput("squareSyncSeen", found, 1);
        checkOutput("squareSyncDa", da_data, 8'd254);
        highs = 0;
        syncs = 0;
        for (int i = 0; i < 64; i++) begin
            if (da_data == 8'd254) highs++;
            if (sync_pulse) syncs++;
            tick(1);
        end
        checkOutput("squareHighs", highs, 32);
        checkOutput("squareSyncsPerPeriod", syncs, 1);
        checkOutput("squareNextSync", sync_pulse, 1'b1);

        highs = 0;
        for (int i = 0; i < 64; i++) begin
            if (da_data == 8'd254) highs++;
            if (i == 10) begin
                checkOutput("pendReadyBefore", cfg_ready, 1'b1);
                setCfg(32'h0400_0000, 8'd64, 8'd255, 8'd0, SQUARE);
                cfg_valid = 1'b1;
            end
            if (i == 11) begin
                checkOutput("pendReadyLow", cfg_ready, 1'b0);
                cfg_valid = 1'b0;
            end
            tick(1);
        end
        checkOutput("pendOldDutyHighs", highs, 32);
        checkOutput("pendWrapSync", sync_pulse, 1'b1);
        checkOutput("pendReadyBack", cfg_ready, 1'b1);
        highs = 0;
        for (int i = 0; i < 64; i++) begin
            if (da_data == 8'd254) highs++;
            tick(1);
        end
        checkOutput("pendNewDutyHighs", highs, 16);

        applyStimulus(32'h0100_0000, 8'd0, 8'd60, 8'd50, SAW);
        checkOutput("rstPendReady", cfg_ready, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("rstMidDa", da_data, 8'd0);
        checkOutput("rstMidSync", sync_pulse, 1'b0);
        checkOutput("rstMidReady", cfg_ready, 1'b1);
        tick(2);
        rst = 1'b0;
        tick(6);
        checkOutput("rstDefaultsDa", da_data, 8'd254);
        checkOutput("rstDefaultsReady", cfg_ready, 1'b1);
        waitSync(70, found, lows);
        checkOutput("rstDefaultsNoSync", found, 0);

        setCfg(32'h0400_0000, 8'd128, 8'd255, 8'd0, SQUARE);
        cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
        checkOutput("freqZeroPend", cfg_ready, 1'b0);
        tick(1);
        checkOutput("freqZeroApplied", cfg_ready, 1'b1);
        waitSync(100, found, lows);
        checkOutput("freqZeroSyncSeen", found, 1);
        checkOutput("freqZeroLowSeen", lows > 0, 1);

        applyStimulus(32'h0400_0000, 8'd128, 8'd90, 8'd30, SQUARE);
        checkOutput("enFallPend", cfg_ready, 1'b0);
        en = 1'b0;
        tick(3);
        checkOutput("enFallShadowMin", da_data, 8'd30);
        checkOutput("enFallReady", cfg_ready, 1'b1);

        en = 1'b1;
        tick(3);
        en = 1'b0;
        applyStimulus(32'h0400_0000, 8'd128, 8'd70, 8'd70, SQUARE);
        tick(2);
        checkOutput("enLowXferDa", da_data, 8'd70);
        checkOutput("enLowXferReady", cfg_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
